// File: rtl/bin2bcd_seq.sv
// Iterative binary-to-BCD converter (shift-add-3 / double dabble).
// One input bit is consumed per clock. The handshake is valid/ready on both sides.
// Inputs above 10^DIGITS-1 produce all nines and raise out_ovf.
module bin2bcd_seq #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      in_bin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic                  out_ovf
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    // One bit wider than the BCD word, so 10^DIGITS-1 always fits
    // and any legal BIN_W zero-extends into it.
    localparam int CMP_W = BCD_W + 1;

    // Largest value representable in DIGITS decimal digits (10^DIGITS - 1).
    function automatic logic [CMP_W-1:0] max_bcd_value();
        logic [CMP_W-1:0] v;
        v = '0;
        for (int i = 0; i < DIGITS; i++) begin
            v = v * CMP_W'(10) + CMP_W'(9);
        end
        return v;
    endfunction

    localparam logic [CMP_W-1:0] MAX_VAL = max_bcd_value();

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic [BCD_W-1:0]   out_bcd_q, out_bcd_d;
    logic               out_ovf_q, out_ovf_d;

    logic [BCD_W-1:0]   bcd_adj;
    logic [BCD_W-1:0]   bcd_step;
    logic [BIN_W-1:0]   bin_step;

    // One double-dabble step: add 3 to each digit >= 5, then shift {bcd, bin} left.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        // The accumulator MSB drops off here. It is zero whenever the input is in range.
        {bcd_step, bin_step} = {bcd_adj, bin_q} << 1;
    end

    // Next-state and datapath decode for IDLE -> SHIFT x BIN_W -> DONE.
    always_comb begin
        // NOTE: every _d gets its hold value first, so no path can leave one unassigned and infer a latch.
        state_d   = state_q;
        bin_d     = bin_q;
        bcd_d     = bcd_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        out_bcd_d = out_bcd_q;
        out_ovf_d = out_ovf_q;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    bin_d   = in_bin;
                    bcd_d   = '0;
                    cnt_d   = CNT_W'(BIN_W);
                    ovf_d   = (CMP_W'(in_bin) > MAX_VAL);
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                bin_d = bin_step;
                bcd_d = bcd_step;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    // Register the result on the final step, so it is ready on entry to DONE.
                    out_bcd_d = ovf_q ? {DIGITS{4'h9}} : bcd_step;
                    out_ovf_d = ovf_q;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any conversion in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            bin_q     <= '0;
            bcd_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            out_bcd_q <= '0;
            out_ovf_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every register updates from pre-edge values.
            state_q   <= state_d;
            bin_q     <= bin_d;
            bcd_q     <= bcd_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            out_bcd_q <= out_bcd_d;
            out_ovf_q <= out_ovf_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign out_bcd   = out_bcd_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq.
// The driver pushes the expected {bcd, ovf} for each accepted input.
// The monitor pops and compares on every output transfer.
module tb_bin2bcd_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [13:0] in_bin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_bcd;
    logic        out_ovf;

    int n_cmp = 0;
    int n_err = 0;

    logic [16:0] sb[$];   // {expected bcd, expected ovf}

    bin2bcd_seq #(.BIN_W(14), .DIGITS(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bin    (in_bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bcd   (out_bcd),
        .out_ovf   (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit digits_ok(input logic [15:0] b);
        for (int i = 0; i < 4; i++) begin
            if (b[4*i +: 4] > 4'd9) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Reference conversion built from decimal division.
    function automatic logic [16:0] ref_conv(input int v);
        logic [15:0] r;
        if (v > 9999) return {16'h9999, 1'b1};
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return {r, 1'b0};
    endfunction

    // Monitor: compares every output transfer against the scoreboard.
    always @(negedge clk) begin
        logic [16:0] e;
        if (rst_n) begin
            check("ready_valid_excl", 32'(in_ready & out_valid), 32'd0);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_output: got %0h expected no transfer", out_bcd);
                end else begin
                    e = sb.pop_front();
                    check("out_bcd", 32'(out_bcd), 32'(e[16:1]));
                    check("out_ovf", 32'(out_ovf), 32'(e[0]));
                    check("digits_le_9", 32'(digits_ok(out_bcd)), 32'd1);
                end
            end
        end
    end

    // Wait for in_ready (optionally with random out_ready stalls), then issue one input.
    task automatic send(input logic [13:0] v, input logic [16:0] e, input bit stall);
        int guard = 0;
        while (!in_ready && guard < 200) begin
            if (stall) out_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            guard++;
        end
        check("in_ready_wait", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_bin   = v;
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    logic [13:0] vec_in  [12] = '{14'd1, 14'd10, 14'd99, 14'd100, 14'd4095, 14'd5000,
                                  14'd8191, 14'd9998, 14'd9999, 14'd10000, 14'd12345, 14'd16383};
    logic [15:0] vec_bcd [12] = '{16'h0001, 16'h0010, 16'h0099, 16'h0100, 16'h4095, 16'h5000,
                                  16'h8191, 16'h9998, 16'h9999, 16'h9999, 16'h9999, 16'h9999};
    logic        vec_ovf [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    initial begin
        int cyc;
        int guard;
        logic [13:0] rv;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_bin    = '0;
        out_ready = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_bcd", 32'(out_bcd), 32'd0);
        check("rst_out_ovf", 32'(out_ovf), 32'd0);
        #11;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Zero input, latency of 14 edges.
        out_ready = 1'b1;
        send(14'd0, {16'h0000, 1'b0}, 1'b0);
        wait_valid(cyc);
        check("lat_zero", 32'(cyc), 32'd14);
        check("zero_bcd", 32'(out_bcd), 32'h0000);
        check("zero_ovf", 32'(out_ovf), 32'd0);

        // 1234: out_valid lasts one cycle with out_ready high, then in_ready returns.
        send(14'h04D2, {16'h1234, 1'b0}, 1'b0);
        wait_valid(cyc);
        check("lat_1234", 32'(cyc), 32'd14);
        check("bcd_1234", 32'(out_bcd), 32'h1234);
        @(posedge clk);
        #1;
        check("valid_one_cycle", 32'(out_valid), 32'd0);
        check("in_ready_back", 32'(in_ready), 32'd1);

        // Range boundary and saturation.
        send(14'd9999,  {16'h9999, 1'b0}, 1'b0);
        send(14'd10000, {16'h9999, 1'b1}, 1'b0);
        send(14'd16383, {16'h9999, 1'b1}, 1'b0);

        // 507 with the consumer stalled; in_valid pulses of 42 must be ignored.
        send(14'd507, {16'h0507, 1'b0}, 1'b0);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_bin   = 14'd42;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        wait_valid(cyc);
        check("stall_valid_seen", 32'(out_valid), 32'd1);
        for (int i = 0; i < 20; i++) begin
            in_valid = (i % 3 == 0);
            in_bin   = 14'd42;
            @(posedge clk);
            #1;
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_bcd", 32'(out_bcd), 32'h0507);
            check("stall_ovf", 32'(out_ovf), 32'd0);
        end
        // The releasing edge must not also accept an input.
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("release_valid_drop", 32'(out_valid), 32'd0);
        check("release_no_accept", 32'(in_ready), 32'd1);
        check("release_sb_empty", 32'(sb.size()), 32'd0);
        check("hold_bcd_after", 32'(out_bcd), 32'h0507);

        // Reset six cycles into converting 8765.
        send(14'd8765, {16'h8765, 1'b0}, 1'b0);
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_bcd", 32'(out_bcd), 32'd0);
        check("abort_ovf", 32'(out_ovf), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(14'd8765, {16'h8765, 1'b0}, 1'b0);
        wait_valid(cyc);
        check("lat_8765", 32'(cyc), 32'd14);
        check("bcd_8765", 32'(out_bcd), 32'h8765);

        // Directed table with random output stalls.
        for (int i = 0; i < 12; i++) begin
            send(vec_in[i], {vec_bcd[i], vec_ovf[i]}, 1'b1);
        end

        // Random sweep against the reference conversion.
        for (int i = 0; i < 40; i++) begin
            rv = 14'($urandom_range(0, 16383));
            send(rv, ref_conv(int'(rv)), 1'b1);
        end

        // Drain the remaining results.
        out_ready = 1'b1;
        guard = 0;
        while (sb.size() != 0 && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("drain_sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
